// File: rtl/acc_stream_pkg.sv
// acc_stream_pkg
// Shared definitions for the streaming accumulator slice:
//   - default widths for the accumulator, the addend and the term counter
//   - the controller state encoding
//   - the widened sum type produced by the add stage (one carry bit on top)
// Optional feature macro used by this slice: ACC_STREAM_SAT_EN (see acc_stream_51).
package acc_stream_pkg;

    localparam int ACC_W  = 51;
    localparam int TERM_W = 13;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Accumulator width plus one carry bit.
    typedef logic [ACC_W:0] sum_t;

endpackage

// File: rtl/acc_add_51_13.sv
// acc_add_51_13
// Purely combinational add stage: a + zero-extended b, with the carry kept
// as the top bit of the result so the caller can detect wrap-around.
// Ports:
//   a    input  A_W     running accumulator operand
//   b    input  B_W     addend, zero-extended to A_W before the add
//   sum  output A_W+1   full sum, bit A_W is the carry-out of bit A_W-1
module acc_add_51_13 #(
    parameter int A_W = acc_stream_pkg::ACC_W,
    parameter int B_W = acc_stream_pkg::TERM_W
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W:0]   sum
);

    // Both operands are widened to A_W+1 so the carry lands in the top bit.
    assign sum = {1'b0, a} + {{(A_W + 1 - B_W){1'b0}}, b};

endmodule

// File: rtl/acc_stream_51.sv
// acc_stream_51
// Sequential accumulator. A job is started in IDLE with an initial value and
// a term count; addends are then taken one per handshake and added into the
// running value, and the final value is offered downstream until taken.
// Optional feature: define ACC_STREAM_SAT_EN to clamp the accumulator to all
// ones on carry-out instead of wrapping modulo 2^ACC_W.
// Ports:
//   clk           input   1       rising-edge clock
//   rst           input   1       synchronous active-high reset
//   start         input   1       begin a job (only looked at in IDLE)
//   num_terms     input   CNT_W   addends in the job, captured with start
//   acc_init      input   ACC_W   starting value, captured with start
//   term_valid    input   1       addend present
//   term_data     input   TERM_W  addend
//   term_ready    output  1       addend accepted this cycle if valid
//   res_valid     output  1       result on res_sum/res_overflow
//   res_ready     input   1       downstream takes the result
//   res_sum       output  ACC_W   final accumulator value
//   res_overflow  output  1       a carry-out happened during the job
//   busy          output  1       a job is in progress (state not IDLE)
module acc_stream_51 #(
    parameter int ACC_W  = acc_stream_pkg::ACC_W,
    parameter int TERM_W = acc_stream_pkg::TERM_W,
    parameter int CNT_W  = acc_stream_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [ACC_W-1:0]  acc_init,
    input  logic              term_valid,
    input  logic [TERM_W-1:0] term_data,
    output logic              term_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic              res_overflow,
    output logic              busy
);

    import acc_stream_pkg::*;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   remaining;
    logic               ovf;
    logic [ACC_W:0]     sum52;
    logic [ACC_W-1:0]   acc_next;

    acc_add_51_13 #(
        .A_W (ACC_W),
        .B_W (TERM_W)
    ) u_add (
        .a   (acc),
        .b   (term_data),
        .sum (sum52)
    );

    // Value written back on an accepted addend. With saturation, a carry pins
    // the accumulator at all ones; once there, any further nonzero addend
    // carries again, so it stays pinned for the rest of the job.
    always_comb begin
`ifdef ACC_STREAM_SAT_EN
        acc_next = sum52[ACC_W] ? {ACC_W{1'b1}} : sum52[ACC_W-1:0];
`else
        acc_next = sum52[ACC_W-1:0];
`endif
    end

    // Controller and datapath registers.
    // The counter is only decremented while nonzero and the job ends on the
    // acceptance that sees remaining==1, so it cannot underflow even for the
    // largest term count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= acc_init;
                        remaining <= num_terms;
                        ovf       <= 1'b0;
                        state     <= (num_terms == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (term_valid) begin
                        acc <= acc_next;
                        ovf <= ovf | sum52[ACC_W];
                        if (remaining != '0) begin
                            remaining <= remaining - CNT_W'(1);
                        end
                        if (remaining <= CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registered state, so the result is
    // stable for as long as res_valid is held.
    assign term_ready   = (state == ACCUM);
    assign res_valid    = (state == DONE);
    assign res_sum      = acc;
    assign res_overflow = ovf;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_acc_stream_51.sv
// tb_acc_stream_51
// Self-checking bench for acc_stream_51. Expected results come from a plain
// arithmetic model of a job: start from the initial value, add each term,
// and on reaching 2^ACC_W either wrap (default) or clamp to all ones
// (ACC_STREAM_SAT_EN), remembering that a carry happened.
module tb_acc_stream_51;

    import acc_stream_pkg::*;

    localparam longint MOD = longint'(1) << ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_terms;
    logic [ACC_W-1:0]  acc_init;
    logic              term_valid;
    logic [TERM_W-1:0] term_data;
    logic              term_ready;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_sum;
    logic              res_overflow;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // Terms of the next job and an optional per-cycle valid pattern.
    int tq[$];
    bit vq[$];

    acc_stream_51 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_terms    (num_terms),
        .acc_init     (acc_init),
        .term_valid   (term_valid),
        .term_data    (term_data),
        .term_ready   (term_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_overflow (res_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result of a whole job.
    function automatic void modelJob(input longint init, output longint sum, output bit ovf);
        longint v;
        v   = init;
        ovf = 1'b0;
        foreach (tq[i]) begin
            v = v + longint'(tq[i]);
            if (v >= MOD) begin
                ovf = 1'b1;
`ifdef ACC_STREAM_SAT_EN
                v = MOD - 1;
`else
                v = v - MOD;
`endif
            end
        end
        sum = v;
    endfunction

    // Runs one complete job using tq as the terms. The valid pattern comes
    // from vq first, then random gaps or back-to-back. hold = cycles the
    // result waits for res_ready; poke_start raises start while busy.
    task automatic applyStimulus(input string name, input logic [ACC_W-1:0] init,
                                 input bit random_gaps, input int hold, input bit poke_start);
        longint esum;
        bit     eovf;
        int     n;
        int     idx;
        int     cyc;
        int     guard;
        bit     v;
        bit     gapped;

        modelJob(longint'(init), esum, eovf);
        n      = tq.size();
        idx    = 0;
        guard  = 0;
        gapped = random_gaps || (vq.size() != 0);

        start     = 1'b1;
        num_terms = CNT_W'(n);
        acc_init  = init;
        step();
        cyc       = 1;
        start     = 1'b0;
        num_terms = CNT_W'($urandom);
        acc_init  = {$urandom, $urandom};

        while (idx < n && guard < 4000) begin
            if (vq.size() != 0)  v = vq.pop_front();
            else if (random_gaps) v = 1'($urandom_range(0, 1));
            else                  v = 1'b1;
            term_valid = v;
            term_data  = v ? TERM_W'(tq[idx]) : TERM_W'($urandom);
            start      = poke_start;
            checkOutput({name, " term_ready"}, 64'(term_ready), 64'd1);
            step();
            cyc++;
            guard++;
            if (v) idx++;
        end
        term_valid = 1'b0;
        start      = 1'b0;

        checkOutput({name, " no_timeout"}, 64'(guard >= 4000), 64'd0);
        if (!gapped) checkOutput({name, " latency"}, 64'(cyc), 64'(n + 1));
        checkOutput({name, " res_valid"}, 64'(res_valid), 64'd1);
        checkOutput({name, " term_ready_done"}, 64'(term_ready), 64'd0);
        checkOutput({name, " res_sum"}, 64'(res_sum), 64'(esum));
        checkOutput({name, " res_overflow"}, 64'(res_overflow), 64'(eovf));

        // Result must hold while downstream stalls; stray addends are ignored.
        for (int h = 0; h < hold; h++) begin
            term_valid = 1'b1;
            term_data  = TERM_W'($urandom);
            step();
            checkOutput({name, " hold_valid"}, 64'(res_valid), 64'd1);
            checkOutput({name, " hold_sum"}, 64'(res_sum), 64'(esum));
            checkOutput({name, " hold_ovf"}, 64'(res_overflow), 64'(eovf));
        end
        term_valid = 1'b0;

        res_ready = 1'b1;
        start     = poke_start;
        step();
        res_ready = 1'b0;
        start     = 1'b0;
        checkOutput({name, " busy_after"}, 64'(busy), 64'd0);
        checkOutput({name, " valid_after"}, 64'(res_valid), 64'd0);
        step();
        checkOutput({name, " still_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [ACC_W-1:0] rinit;
        int               rn;

        rst        = 1'b1;
        start      = 1'b0;
        num_terms  = '0;
        acc_init   = '0;
        term_valid = 1'b0;
        term_data  = '0;
        res_ready  = 1'b0;
        step();
        step();
        checkOutput("reset res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset term_ready", 64'(term_ready), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset res_sum", 64'(res_sum), 64'd0);
        checkOutput("reset res_overflow", 64'(res_overflow), 64'd0);
        rst = 1'b0;
        step();

        $display("[TB] basic 1+2+3");
        tq = {1, 2, 3};
        applyStimulus("basic", 51'd0, 1'b0, 0, 1'b0);
        checkOutput("basic literal sum", 64'(res_sum), 64'd6);

        $display("[TB] zero terms");
        tq.delete();
        applyStimulus("zero", 51'h1234, 1'b0, 1, 1'b0);
        checkOutput("zero literal sum", 64'(res_sum), 64'h1234);

        $display("[TB] carry out");
        tq = {13'h1FFF};
        applyStimulus("carry", 51'(MOD - 2), 1'b0, 0, 1'b0);

        $display("[TB] gappy source");
        tq = {5, 7, 9};
        vq = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        applyStimulus("gappy", 51'd0, 1'b0, 3, 1'b0);
        checkOutput("gappy literal sum", 64'(res_sum), 64'd21);

        $display("[TB] reset mid job");
        start     = 1'b1;
        num_terms = 8'd4;
        acc_init  = 51'h55;
        step();
        start      = 1'b0;
        term_valid = 1'b1;
        term_data  = 13'd100;
        step();
        step();
        term_valid = 1'b0;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort res_valid", 64'(res_valid), 64'd0);
        checkOutput("abort term_ready", 64'(term_ready), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort res_sum", 64'(res_sum), 64'd0);
        checkOutput("abort res_overflow", 64'(res_overflow), 64'd0);
        tq = {8};
        applyStimulus("after_abort", 51'd0, 1'b0, 0, 1'b0);

        $display("[TB] start while busy");
        tq = {300, 4000, 17, 8191};
        applyStimulus("poke", 51'(MOD - 5000), 1'b0, 2, 1'b1);

        $display("[TB] maximum term count");
        tq.delete();
        for (int i = 0; i < 255; i++) tq.push_back(int'($urandom_range(0, 8191)));
        applyStimulus("max_terms", 51'(MOD - 1000000), 1'b0, 0, 1'b0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 8; j++) begin
            tq.delete();
            rn = int'($urandom_range(1, 24));
            for (int i = 0; i < rn; i++) tq.push_back(int'($urandom_range(0, 8191)));
            if (j % 2 == 0) rinit = 51'(MOD - 1 - longint'($urandom_range(0, 60000)));
            else            rinit = {$urandom, $urandom};
            applyStimulus("random", rinit, 1'b1, int'($urandom_range(0, 3)), 1'(j % 3 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
